rto_event_arbiter: RTL and testbench
====================================

// Module: rto_event_arbiter
// PURPOSE
//  Merges timed events from NUM_REQ RTOB_Core instances onto one shared GPO/TTL controller input.
//  Each core emits a one-cycle counter_matched pulse with a 72-bit rto_out word and cannot be stalled.
//  Each requester has a one-entry pending slot; round-robin grant forwards one event per cycle when downstream is not busy.
//  Sits between the RTOB_Core array and a single TTLx8_Controller (counter_matched/gpo_in/busy).
// PARAMETERS
//  NUM_REQ    4   number of RTOB_Core requesters (2..8)
//  DATA_WIDTH 72  rto_out word width
//  IDX_WIDTH  $clog2(NUM_REQ)  width of grant index
// PORTS
//  clk              in   1                    system clock (s_axi_aclk domain)
//  reset            in   1                    synchronous, active-high reset
//  req_matched      in   NUM_REQ              per-requester counter_matched pulse
//  req_data         in   NUM_REQ*DATA_WIDTH   per-requester rto_out, requester i at [i*72 +: 72]
//  busy             in   1                    downstream busy; no grant while high
//  clear_error      in   1                    clears sticky overflow flags and overflow_data
//  out_matched      out  1                    one-cycle pulse to controller counter_matched
//  out_data         out  DATA_WIDTH           word for controller gpo_in, valid with out_matched
//  out_src          out  IDX_WIDTH            requester index of current out_data
//  pending          out  NUM_REQ              pending-slot occupancy
//  overflow_error   out  NUM_REQ              sticky: event arrived while slot full and not granted
//  overflow_data    out  DATA_WIDTH           first dropped word since last clear
// BEHAVIOUR
//  Reset: out_matched=0, out_data=0, out_src=0, pending=0, overflow_error=0, overflow_data=0, rr pointer=0.
//  Capture: req_matched[i]=1 -> slot i <= req_data[i], pending[i] set, on the next edge.
//  Grant (cycle t): if busy=0 and |pending, pick the first pending index at or above ptr, wrapping modulo NUM_REQ.
//    Registered outputs: out_matched=1, out_data=slot[g], out_src=g at t+1; pending[g] cleared; ptr <= (g+1) mod NUM_REQ.
//  Latency: an event into an empty arbiter with busy=0 appears 2 cycles after the req_matched pulse (capture, then grant).
//  No grant -> out_matched=0; out_data/out_src hold their last values.
//  busy=1: no grant; pending slots hold; ptr unchanged.
//  Same-cycle grant of g and new req_matched[g]: old word forwarded, new word captured, pending[g] stays 1. No overflow.
//  Slot full, not granted, and req_matched[i]=1: new word dropped, old word kept.
//    overflow_error[i] set; overflow_data latched only if no overflow_error bit was already set.
//  clear_error together with a new overflow: the new overflow wins (flag set, data latched).
//  reset mid-operation: all pending events discarded; no out_matched pulse in the reset cycle or the cycle after.
// CONFIGURATION
//  RTO_EVENT_ARBITER_STATS_EN
//    defined: adds output grant_count [NUM_REQ*32], one 32-bit saturating counter per requester.
//      Increments on each grant; reset and clear_error zero it.
//    undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package rto_arb_pkg:
//    typedef logic [71:0] rto_word_t
//    localparam RTO_DATA_WIDTH = 72
//    function rr_pick(pending, ptr) returning {found, index}
//  Sub-module rto_rr_picker: combinational round-robin first-set-from-pointer selector, NUM_REQ-parameterised.
//  Top: pending slots, overflow logic, output register, pointer register.
// TESTING
//  1. Single event: req_matched[1] pulse, data 72'h0A_0000_0000_0000_0055, busy=0
//     -> out_matched 2 cycles later, out_data equal to input, out_src=1, pending=0.
//  2. Fairness: req_matched=4'b1111 same cycle, ptr=0
//     -> grants on 4 consecutive cycles, out_src 0,1,2,3; ptr ends at 0.
//  3. Backpressure: req 2 pending, busy=1 for 10 cycles -> no out_matched; busy falls -> pulse within 1 cycle, out_src=2.
//  4. Overflow: busy=1, two pulses on req 3 (data A then B)
//     -> overflow_error=4'b1000, overflow_data=B; after busy falls A is forwarded; clear_error -> flags 0.
//  5. Grant/capture collision: req 0 pending, new pulse on req 0 in its grant cycle
//     -> old word out, new word forwarded next, overflow_error=0.
//  6. Reset mid-run: 3 slots pending, reset pulse -> pending=0, no out_matched for 2 cycles; STATS_EN build: grant_count all 0.

Source files
------------

// File: rtl/rto_arb_pkg.sv
// Shared types and helpers for the RTO event arbiter.
// The round-robin search is written once here and wrapped by rto_rr_picker.
package rto_arb_pkg;

  localparam int RTO_DATA_WIDTH = 72;
  localparam int RR_MAX_REQ     = 8;

  typedef logic [RTO_DATA_WIDTH-1:0] rto_word_t;

  typedef struct packed {
    logic       found;
    logic [2:0] index;
  } rr_pick_t;

  // First set bit of pend at or above ptr, wrapping modulo n (n <= RR_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] pend,
                                       input logic [2:0]            ptr,
                                       input int unsigned           n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned s = 0; s < RR_MAX_REQ; s++) begin
      if (s < n && !r.found) begin
        k = ({29'b0, ptr} + s) % n;
        if (pend[k[2:0]]) begin
          r.found = 1'b1;
          r.index = k[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rto_rr_picker.sv
// Combinational round-robin selector: first pending requester at or above
// the pointer, wrapping around NUM_REQ.
module rto_rr_picker
  import rto_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   pending,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [RR_MAX_REQ-1:0] pend_ext;
  logic [2:0]            ptr_ext;
  rr_pick_t              pick;
  logic                  unused_idx_bits;

  // Widen to the helper's fixed width and run the search.
  always_comb begin
    pend_ext                = '0;
    pend_ext[NUM_REQ-1:0]   = pending;
    ptr_ext                 = '0;
    ptr_ext[IDX_WIDTH-1:0]  = ptr;
    pick                    = rr_pick(pend_ext, ptr_ext, NUM_REQ);
    found                   = pick.found;
    idx                     = pick.index[IDX_WIDTH-1:0];
  end

  // Upper index bits are always zero for small NUM_REQ.
  assign unused_idx_bits = ^pick.index;

endmodule

// File: rtl/rto_event_arbiter.sv
// Merges one-cycle timed events from NUM_REQ RTOB cores onto a single
// TTL/GPO controller input. Each requester owns a one-entry pending slot;
// a round-robin grant forwards at most one event per cycle while busy is low.
// Optional: define RTO_EVENT_ARBITER_STATS_EN to add per-requester
// saturating grant counters on output grant_count.
module rto_event_arbiter
  import rto_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = RTO_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_matched,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          busy,
  input  logic                          clear_error,
  output logic                          out_matched,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_WIDTH-1:0]          out_src,
  output logic [NUM_REQ-1:0]            pending,
  output logic [NUM_REQ-1:0]            overflow_error,
  output logic [DATA_WIDTH-1:0]         overflow_data
`ifdef RTO_EVENT_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_count
`endif
);

  logic [NUM_REQ-1:0]            pending_q, pending_d;
  logic [NUM_REQ-1:0]            overflow_error_q, overflow_error_d;
  logic [DATA_WIDTH-1:0]         overflow_data_q, overflow_data_d;
  logic                          out_matched_q, out_matched_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [IDX_WIDTH-1:0]          out_src_q, out_src_d;
  logic [IDX_WIDTH-1:0]          ptr_q, ptr_d;

  logic [NUM_REQ*DATA_WIDTH-1:0] slot_flat;
  logic                          pick_found;
  logic [IDX_WIDTH-1:0]          grant_idx;
  logic                          grant_en;
  logic [NUM_REQ-1:0]            grant_vec;
  logic [NUM_REQ-1:0]            ovf_vec;
  logic [DATA_WIDTH-1:0]         ovf_word;

  rto_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .pending (pending_q),
    .ptr     (ptr_q),
    .found   (pick_found),
    .idx     (grant_idx)
  );

  assign grant_en = pick_found && !busy;

  // One-hot view of this cycle's grant.
  always_comb begin
    grant_vec = '0;
    if (grant_en) grant_vec[grant_idx] = 1'b1;
  end

  // A slot can take a new word when empty or when its old word leaves this cycle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;

    // Capture the requester's word into its pending slot.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_q <= '0;
      end else if (req_matched[gi] && (!pending_q[gi] || grant_vec[gi])) begin
        slot_q <= req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign slot_flat[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end

  // Output word, source index, pending set and rr pointer next state.
  always_comb begin
    out_matched_d = grant_en;
    out_src_d     = out_src_q;
    out_data_d    = out_data_q;
    ptr_d         = ptr_q;
    if (grant_en) begin
      out_src_d = grant_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == IDX_WIDTH'(i)) out_data_d = slot_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
      ptr_d = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
    end
    // A granted slot that is refilled in the same cycle stays pending.
    pending_d = (pending_q & ~grant_vec) | req_matched;
  end

  // Overflow detection: a new event hits a full slot that is not leaving.
  always_comb begin
    ovf_vec  = req_matched & pending_q & ~grant_vec;
    ovf_word = '0;
    // Lowest overflowing requester supplies the captured word.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (ovf_vec[i]) ovf_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    overflow_error_d = (clear_error ? '0 : overflow_error_q) | ovf_vec;
    overflow_data_d  = clear_error ? '0 : overflow_data_q;
    // Keep only the first dropped word; a clear in the same cycle lets the new one in.
    if (|ovf_vec && (clear_error || !(|overflow_error_q))) overflow_data_d = ovf_word;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q        <= '0;
      overflow_error_q <= '0;
      overflow_data_q  <= '0;
      out_matched_q    <= 1'b0;
      out_data_q       <= '0;
      out_src_q        <= '0;
      ptr_q            <= '0;
    end else begin
      pending_q        <= pending_d;
      overflow_error_q <= overflow_error_d;
      overflow_data_q  <= overflow_data_d;
      out_matched_q    <= out_matched_d;
      out_data_q       <= out_data_d;
      out_src_q        <= out_src_d;
      ptr_q            <= ptr_d;
    end
  end

  assign out_matched    = out_matched_q;
  assign out_data       = out_data_q;
  assign out_src        = out_src_q;
  assign pending        = pending_q;
  assign overflow_error = overflow_error_q;
  assign overflow_data  = overflow_data_q;

`ifdef RTO_EVENT_ARBITER_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [31:0] cnt_q;

    // Saturating per-requester grant counter.
    always_ff @(posedge clk) begin
      if (reset || clear_error) begin
        cnt_q <= '0;
      end else if (grant_vec[gi] && cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign grant_count[gi*32 +: 32] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rto_event_arbiter.sv
// Directed, table-driven bench for rto_event_arbiter (NUM_REQ=4).
// Requester i receives the cycle's base word XOR {i, 64'h0}.
module tb_rto_event_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_matched;
  logic [287:0] req_data;
  logic         busy;
  logic         clear_error;
  logic         out_matched;
  logic [71:0]  out_data;
  logic [1:0]   out_src;
  logic [3:0]   pending;
  logic [3:0]   overflow_error;
  logic [71:0]  overflow_data;
`ifdef RTO_EVENT_ARBITER_STATS_EN
  logic [127:0] grant_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rto_event_arbiter #(.NUM_REQ(4), .DATA_WIDTH(72)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_matched    (req_matched),
    .req_data       (req_data),
    .busy           (busy),
    .clear_error    (clear_error),
    .out_matched    (out_matched),
    .out_data       (out_data),
    .out_src        (out_src),
    .pending        (pending),
    .overflow_error (overflow_error),
    .overflow_data  (overflow_data)
`ifdef RTO_EVENT_ARBITER_STATS_EN
    ,
    .grant_count    (grant_count)
`endif
  );

  typedef struct {
    logic [3:0]  req;
    logic [71:0] data;
    logic        busy;
    logic        clr;
    logic        exp_m;
    logic [1:0]  exp_src;
    logic [71:0] exp_data;
    logic [3:0]  exp_pend;
    logic [3:0]  exp_ovf;
    logic [71:0] exp_ovd;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic [3:0] r, input logic [71:0] d, input logic b,
                              input logic c, input logic m, input logic [1:0] s,
                              input logic [71:0] ed, input logic [3:0] p,
                              input logic [3:0] o, input logic [71:0] od);
    vec_t v;
    v.req = r; v.data = d; v.busy = b; v.clr = c; v.exp_m = m; v.exp_src = s;
    v.exp_data = ed; v.exp_pend = p; v.exp_ovf = o; v.exp_ovd = od;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [71:0] d, input logic b, input logic c);
    req_matched = r;
    busy        = b;
    clear_error = c;
    for (int i = 0; i < 4; i++) req_data[i*72 +: 72] = d ^ {8'(i), 64'h0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rows: inputs for one cycle, then expected registered outputs after that edge.
    tbl[0]  = mk(4'b0010, 72'h0B_0000_0000_0000_0055, 0, 0, 0, 0, 72'h0, 4'b0010, 4'b0, 72'h0);
    tbl[1]  = mk(4'b0000, 72'h0, 0, 0, 1, 1, 72'h0A_0000_0000_0000_0055, 4'b0000, 4'b0, 72'h0);
    tbl[2]  = mk(4'b0000, 72'h0, 0, 0, 0, 1, 72'h0A_0000_0000_0000_0055, 4'b0000, 4'b0, 72'h0);
    tbl[3]  = mk(4'b1000, 72'h00_1111_2222_3333_4444, 0, 0, 0, 1, 72'h0A_0000_0000_0000_0055, 4'b1000, 4'b0, 72'h0);
    tbl[4]  = mk(4'b0000, 72'h0, 0, 0, 1, 3, 72'h03_1111_2222_3333_4444, 4'b0000, 4'b0, 72'h0);
    tbl[5]  = mk(4'b1111, 72'h00_AAAA_BBBB_CCCC_DDDD, 0, 0, 0, 3, 72'h03_1111_2222_3333_4444, 4'b1111, 4'b0, 72'h0);
    tbl[6]  = mk(4'b0000, 72'h0, 0, 0, 1, 0, 72'h00_AAAA_BBBB_CCCC_DDDD, 4'b1110, 4'b0, 72'h0);
    tbl[7]  = mk(4'b0000, 72'h0, 0, 0, 1, 1, 72'h01_AAAA_BBBB_CCCC_DDDD, 4'b1100, 4'b0, 72'h0);
    tbl[8]  = mk(4'b0000, 72'h0, 0, 0, 1, 2, 72'h02_AAAA_BBBB_CCCC_DDDD, 4'b1000, 4'b0, 72'h0);
    tbl[9]  = mk(4'b0000, 72'h0, 0, 0, 1, 3, 72'h03_AAAA_BBBB_CCCC_DDDD, 4'b0000, 4'b0, 72'h0);
    tbl[10] = mk(4'b0000, 72'h0, 0, 0, 0, 3, 72'h03_AAAA_BBBB_CCCC_DDDD, 4'b0000, 4'b0, 72'h0);
    tbl[11] = mk(4'b1000, 72'h00_0000_0000_0000_00A1, 1, 0, 0, 3, 72'h03_AAAA_BBBB_CCCC_DDDD, 4'b1000, 4'b0, 72'h0);
    tbl[12] = mk(4'b1000, 72'h00_0000_0000_0000_00B2, 1, 0, 0, 3, 72'h03_AAAA_BBBB_CCCC_DDDD, 4'b1000, 4'b1000, 72'h03_0000_0000_0000_00B2);
    tbl[13] = mk(4'b0000, 72'h0, 0, 0, 1, 3, 72'h03_0000_0000_0000_00A1, 4'b0000, 4'b1000, 72'h03_0000_0000_0000_00B2);
    tbl[14] = mk(4'b0000, 72'h0, 0, 1, 0, 3, 72'h03_0000_0000_0000_00A1, 4'b0000, 4'b0000, 72'h0);
    tbl[15] = mk(4'b0001, 72'h00_0000_0000_0000_0C01, 1, 0, 0, 3, 72'h03_0000_0000_0000_00A1, 4'b0001, 4'b0000, 72'h0);
    tbl[16] = mk(4'b0001, 72'h00_0000_0000_0000_0C02, 1, 0, 0, 3, 72'h03_0000_0000_0000_00A1, 4'b0001, 4'b0001, 72'h00_0000_0000_0000_0C02);
    tbl[17] = mk(4'b0001, 72'h00_0000_0000_0000_0C03, 1, 0, 0, 3, 72'h03_0000_0000_0000_00A1, 4'b0001, 4'b0001, 72'h00_0000_0000_0000_0C02);
    tbl[18] = mk(4'b0001, 72'h00_0000_0000_0000_0C04, 1, 1, 0, 3, 72'h03_0000_0000_0000_00A1, 4'b0001, 4'b0001, 72'h00_0000_0000_0000_0C04);
    tbl[19] = mk(4'b0000, 72'h0, 0, 0, 1, 0, 72'h00_0000_0000_0000_0C01, 4'b0000, 4'b0001, 72'h00_0000_0000_0000_0C04);
    tbl[20] = mk(4'b0000, 72'h0, 0, 1, 0, 0, 72'h00_0000_0000_0000_0C01, 4'b0000, 4'b0000, 72'h0);

    // Reset state.
    reset = 1'b1;
    drive(4'b0, 72'h0, 1'b0, 1'b0);
    tick;
    tick;
    chk("reset_out_matched", 72'(out_matched), 72'h0);
    chk("reset_out_data", out_data, 72'h0);
    chk("reset_out_src", 72'(out_src), 72'h0);
    chk("reset_pending", 72'(pending), 72'h0);
    chk("reset_ovf", 72'(overflow_error), 72'h0);
    chk("reset_ovd", overflow_data, 72'h0);
    $display("txn reset: out_matched=%0b pending=%b", out_matched, pending);
    reset = 1'b0;
    tick;

    // Single event, fairness, overflow and clear sequences.
    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].req, tbl[k].data, tbl[k].busy, tbl[k].clr);
      tick;
      chk($sformatf("v%0d_out_matched", k), 72'(out_matched), 72'(tbl[k].exp_m));
      chk($sformatf("v%0d_out_src", k), 72'(out_src), 72'(tbl[k].exp_src));
      chk($sformatf("v%0d_out_data", k), out_data, tbl[k].exp_data);
      chk($sformatf("v%0d_pending", k), 72'(pending), 72'(tbl[k].exp_pend));
      chk($sformatf("v%0d_ovf", k), 72'(overflow_error), 72'(tbl[k].exp_ovf));
      chk($sformatf("v%0d_ovd", k), overflow_data, tbl[k].exp_ovd);
      $display("txn v%0d: req=%b busy=%0b clr=%0b -> m=%0b src=%0d data=%h pend=%b ovf=%b",
               k, tbl[k].req, tbl[k].busy, tbl[k].clr, out_matched, out_src, out_data, pending, overflow_error);
    end

    // Backpressure: requester 2 held off by busy for 10 cycles (ptr is 1 here).
    drive(4'b0100, 72'h00_0000_0000_0000_0D0D, 1'b1, 1'b0);
    tick;
    chk("bp_capture_pending", 72'(pending), 72'h4);
    for (int k = 0; k < 10; k++) begin
      drive(4'b0000, 72'h0, 1'b1, 1'b0);
      tick;
      chk($sformatf("bp_hold%0d_out_matched", k), 72'(out_matched), 72'h0);
      chk($sformatf("bp_hold%0d_pending", k), 72'(pending), 72'h4);
    end
    drive(4'b0000, 72'h0, 1'b0, 1'b0);
    tick;
    chk("bp_release_out_matched", 72'(out_matched), 72'h1);
    chk("bp_release_out_src", 72'(out_src), 72'h2);
    chk("bp_release_out_data", out_data, 72'h02_0000_0000_0000_0D0D);
    chk("bp_release_pending", 72'(pending), 72'h0);
    $display("txn backpressure: m=%0b src=%0d data=%h", out_matched, out_src, out_data);

    // Grant/capture collision on requester 0 (ptr is 3, so the search wraps to 0).
    drive(4'b0001, 72'h00_0000_0000_0000_0E01, 1'b0, 1'b0);
    tick;
    chk("col_capture_pending", 72'(pending), 72'h1);
    drive(4'b0001, 72'h00_0000_0000_0000_0E02, 1'b0, 1'b0);
    tick;
    chk("col_grant_out_matched", 72'(out_matched), 72'h1);
    chk("col_grant_out_data", out_data, 72'h00_0000_0000_0000_0E01);
    chk("col_grant_pending", 72'(pending), 72'h1);
    chk("col_grant_ovf", 72'(overflow_error), 72'h0);
    drive(4'b0000, 72'h0, 1'b0, 1'b0);
    tick;
    chk("col_next_out_matched", 72'(out_matched), 72'h1);
    chk("col_next_out_src", 72'(out_src), 72'h0);
    chk("col_next_out_data", out_data, 72'h00_0000_0000_0000_0E02);
    chk("col_next_pending", 72'(pending), 72'h0);
    chk("col_next_ovf", 72'(overflow_error), 72'h0);
    $display("txn collision: m=%0b data=%h ovf=%b", out_matched, out_data, overflow_error);

    // Reset mid-run with three slots pending.
    drive(4'b0111, 72'h00_0000_0000_0000_0F0F, 1'b1, 1'b0);
    tick;
    chk("rst_pre_pending", 72'(pending), 72'h7);
    drive(4'b0000, 72'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_cyc0_out_matched", 72'(out_matched), 72'h0);
    chk("rst_cyc0_pending", 72'(pending), 72'h0);
    chk("rst_cyc0_out_data", out_data, 72'h0);
    tick;
    chk("rst_cyc1_out_matched", 72'(out_matched), 72'h0);
    chk("rst_cyc1_pending", 72'(pending), 72'h0);
    tick;
    chk("rst_cyc2_out_matched", 72'(out_matched), 72'h0);
`ifdef RTO_EVENT_ARBITER_STATS_EN
    checks++;
    if (grant_count !== 128'h0) begin
      errors++;
      $display("FAIL rst_grant_count: got %h expected 0", grant_count);
    end
`endif
    $display("txn reset_mid_run: m=%0b pending=%b", out_matched, pending);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
